// File: rtl/cmd_frame_rx_if.sv
// cmd_frame_rx_if: serial line, enable and decoded command outputs
// of the command frame receiver.
interface cmd_frame_rx_if #(
  parameter int cmd_l = 4
);
  logic             en;
  logic             rx;
  logic [cmd_l-1:0] speed_cmd_o;
  logic [cmd_l-1:0] dir_cmd_o;
  logic [1:0]       mode_o;
  logic             frame_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output en, rx,
    input  speed_cmd_o, dir_cmd_o, mode_o,
    input  frame_valid, frame_err, busy
  );

  modport slave (
    input  en, rx,
    output speed_cmd_o, dir_cmd_o, mode_o,
    output frame_valid, frame_err, busy
  );
endinterface

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: UART 8N1 byte receiver feeding a 4-byte
// command frame parser (HDR, B1, B2, checksum).
module cmd_frame_rx #(
  parameter int          cmd_l        = 4,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HDR          = 8'hA5,
  parameter int          BYTE_TO      = 4096,
  parameter int          def_dir_cmd  = 8
) (
  input logic          clk,
  input logic          rst_n,
  cmd_frame_rx_if.slave bus
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TOW = $clog2(BYTE_TO + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [TOW-1:0] TO_MAX = TOW'(BYTE_TO - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } r_st_e;

  typedef enum logic [1:0] {
    HUNT, GET_B1, GET_B2, GET_CK
  } p_st_e;

  logic          rx_s1, rx_s2, rx_d;
  logic          fall;
  r_st_e         r_st, r_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sr;
  logic          byte_done, byte_bad;

  p_st_e          p_st, p_nxt;
  logic [7:0]     b1, b2;
  logic [TOW-1:0] to_cnt;
  logic           to_hit, ck_ok;
  logic           fv_d, fe_d;

  logic [cmd_l-1:0] speed_q, dir_q;
  logic [1:0]       mode_q;
  logic             fv_q, fe_q;

  // two-flop synchronizer plus one delay stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= R_IDLE;
    else        r_st <= r_nxt;
  end

  // receiver next state; start bit is rechecked at mid-bit
  always_comb begin
    r_nxt = r_st;
    if (!bus.en) begin
      r_nxt = R_IDLE;
    end else begin
      unique case (r_st)
        R_IDLE:  if (fall) r_nxt = R_START;
        R_START: if (cnt == HALF)
                   r_nxt = rx_s2 ? R_IDLE : R_DATA;
        R_DATA:  if (cnt == FULL && bitn == 3'd7)
                   r_nxt = R_STOP;
        R_STOP:  if (cnt == FULL) r_nxt = R_IDLE;
      endcase
    end
  end

  // bit timer, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      bitn <= '0;
      sr   <= '0;
    end else if (!bus.en || r_st == R_IDLE) begin
      cnt  <= '0;
      bitn <= '0;
    end else begin
      if (r_st == R_START && cnt == HALF) cnt <= '0;
      else if (cnt == FULL)               cnt <= '0;
      else                                cnt <= cnt + 1'b1;
      if (r_st == R_DATA && cnt == FULL) begin
        sr   <= {rx_s2, sr[7:1]};
        bitn <= bitn + 3'd1;
      end
    end
  end

  // stop-bit sample outcome
  always_comb begin
    byte_done = 1'b0;
    byte_bad  = 1'b0;
    if (bus.en && r_st == R_STOP && cnt == FULL) begin
      byte_done = rx_s2;
      byte_bad  = ~rx_s2;
    end
  end

  assign ck_ok  = (sr == (HDR ^ b1 ^ b2)) && (b2[7:2] == 6'd0);
  assign to_hit = (p_st != HUNT) && !byte_done && !byte_bad
                  && (to_cnt == TO_MAX);

  // parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_st <= HUNT;
    else        p_st <= p_nxt;
  end

  // parser next state
  always_comb begin
    p_nxt = p_st;
    if (!bus.en) begin
      p_nxt = HUNT;
    end else if (p_st == HUNT) begin
      if (byte_done && sr == HDR) p_nxt = GET_B1;
    end else if (byte_bad || to_hit) begin
      p_nxt = HUNT;
    end else if (byte_done) begin
      unique case (p_st)
        GET_B1:  p_nxt = GET_B2;
        GET_B2:  p_nxt = GET_CK;
        default: p_nxt = HUNT;
      endcase
    end
  end

  // parser pulse decode
  always_comb begin
    fv_d = 1'b0;
    fe_d = 1'b0;
    if (bus.en && p_st != HUNT) begin
      unique case (1'b1)
        byte_bad, to_hit: fe_d = 1'b1;
        byte_done:
          if (p_st == GET_CK) begin
            fv_d = ck_ok;
            fe_d = ~ck_ok;
          end
        default: ;
      endcase
    end
  end

  // byte latches, inter-byte timeout and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b1      <= '0;
      b2      <= '0;
      to_cnt  <= '0;
      speed_q <= '0;
      dir_q   <= cmd_l'(def_dir_cmd);
      mode_q  <= 2'd3;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      if (p_st == GET_B1 && byte_done) b1 <= sr;
      if (p_st == GET_B2 && byte_done) b2 <= sr;
      if (!bus.en || p_st == HUNT || byte_done || byte_bad)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (fv_d) begin
        speed_q <= b1[7:4];
        dir_q   <= b1[3:0];
        mode_q  <= b2[1:0];
      end
      fv_q <= fv_d;
      fe_q <= fe_d;
    end
  end

  assign bus.speed_cmd_o = speed_q;
  assign bus.dir_cmd_o   = dir_q;
  assign bus.mode_o      = mode_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;
  assign bus.busy        = (p_st != HUNT);

endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 Parameter cmd_l, default 4, command field width (fixed at 4 by frame format).
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (even, >=8).
REQ-003 Parameter HDR, default 8'hA5, frame header byte.
REQ-004 Parameter BYTE_TO, default 4096, inter-byte timeout in clk cycles.
REQ-005 Parameter def_dir_cmd, default 8, dir_cmd_o reset value.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  receiver enable.
REQ-009 rx  input  1  asynchronous serial line, idle high, UART 8N1, LSB first.
REQ-010 speed_cmd_o  output  cmd_l  last accepted speed command.
REQ-011 dir_cmd_o  output  cmd_l  last accepted direction command.
REQ-012 mode_o  output  2  last accepted operation mode.
REQ-013 frame_valid  output  1  one-cycle pulse, frame accepted.
REQ-014 frame_err  output  1  one-cycle pulse, frame rejected.
REQ-015 busy  output  1  high while parser is outside HUNT.

Function
REQ-016 rx SHALL pass a 2-flop synchronizer before any use; all timing is measured from the synchronized signal.
REQ-017 Byte receiver: synchronized 1->0 edge while idle starts a byte; start bit re-checked at CLKS_PER_BIT/2, if high it is a glitch: return to idle, no byte, no error.
REQ-018 Data bits sampled at each subsequent CLKS_PER_BIT interval (mid-bit), 8 bits LSB first, then stop bit sampled at mid-bit.
REQ-019 Stop bit 1 -> byte_done pulse with data; stop bit 0 -> byte_bad pulse; receiver returns to idle after the stop-bit sample either way.
REQ-020 Frame = 4 bytes: HDR; B1 = {speed[3:0], dir[3:0]}; B2 = {6'b0, mode[1:0]}; CK = HDR ^ B1 ^ B2.
REQ-021 Parser FSM states HUNT, GET_B1, GET_B2, GET_CK.
REQ-022 HUNT: byte == HDR -> GET_B1; any other byte or byte_bad discarded silently, stay HUNT.
REQ-023 GET_B1 -> GET_B2 on byte_done (B1 latched); GET_B2 -> GET_CK on byte_done (B2 latched).
REQ-024 GET_CK on byte_done: CK match and B2[7:2]==0 -> load outputs, frame_valid; otherwise frame_err, outputs unchanged; both -> HUNT.
REQ-025 byte_bad in GET_B1/GET_B2/GET_CK -> frame_err, HUNT.
REQ-026 Timeout counter clears on every byte_done/byte_bad; reaching BYTE_TO outside HUNT -> frame_err, HUNT; counter idle in HUNT.
REQ-027 Latency: outputs update and frame_valid asserts on the clock edge following the CK stop-bit sample (1 cycle).
REQ-028 frame_valid and frame_err SHALL never assert in the same cycle; each is exactly one cycle wide.
REQ-029 en low: byte receiver and parser forced idle/HUNT, counters cleared, pulses low, speed/dir/mode held; a byte in flight is dropped without error.
REQ-030 en rising mid-byte: receiver waits for the next 1->0 edge from idle.
REQ-031 busy = (state != HUNT).

Reset
REQ-032 rst_n low asynchronously: speed_cmd_o=0, dir_cmd_o=def_dir_cmd, mode_o=2'd3 (sleep), frame_valid=0, frame_err=0, busy=0, parser HUNT, receiver idle, synchronizer flops=1.
REQ-033 Reset mid-frame discards partial frame; no pulse is emitted on or after reset release until a new complete frame arrives.

Verification
REQ-034 CLKS_PER_BIT=16, en=1: send A5,5C,01,F8 -> one frame_valid pulse; speed_cmd_o=5, dir_cmd_o=C, mode_o=1; frame_err stays 0.
REQ-035 Send A5,5C,01,00 -> one frame_err pulse; outputs stay at reset values 0/8/3.
REQ-036 Send 00,33 then A5,3A,02,9D -> no pulses for noise bytes; then frame_valid, speed=3, dir=A, mode=2.
REQ-037 Send A5 then B1 with stop bit 0 -> frame_err, busy=0; following valid frame A5,5C,01,F8 accepted.
REQ-038 Send A5,5C then idle BYTE_TO cycles -> frame_err exactly once, busy falls; outputs unchanged.
REQ-039 Assert rst_n low during GET_B2, release, send remaining 01,F8 -> no pulses; full A5,5C,01,F8 afterwards -> frame_valid.
